// File: rtl/stack_alu_param.sv
// Parametrised stack ALU: an N-bit x DEPTH LIFO with signed ADD/SUB/MUL, DUP/SWAP/CLEAR and occupancy status.
// Define STACK_ALU_SAT_EN to clamp overflowing arithmetic results instead of wrapping them.
module stack_alu_param #(
    parameter int N     = 32,
    parameter int DEPTH = 16,
    localparam int CW   = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [3:0]    opcode,
    input  logic [N-1:0]  input_data,
    output logic [N-1:0]  output_data,
    output logic          overflow,
    output logic          error,
    output logic          empty,
    output logic          full,
    output logic [CW-1:0] count
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [3:0] {
        OP_NOP   = 4'b0000,
        OP_ADD   = 4'b0100,
        OP_MUL   = 4'b0101,
        OP_PUSH  = 4'b0110,
        OP_POP   = 4'b0111,
        OP_SUB   = 4'b1000,
        OP_DUP   = 4'b1001,
        OP_SWAP  = 4'b1010,
        OP_CLEAR = 4'b1011
    } op_t;

    logic [N-1:0]  mem [DEPTH];
    logic [CW-1:0] count_reg, count_next;
    logic [N-1:0]  out_reg, out_next;
    logic          ovf_reg, ovf_next;
    logic          err_reg, err_next;

    logic [AW-1:0] push_idx, top_idx, sec_idx;
    logic [N-1:0]  top_val, sec_val;
    logic          has_two;

    // The stack pointer equals count; the index arithmetic wraps modulo DEPTH.
    assign push_idx = count_reg[AW-1:0];
    assign top_idx  = push_idx - AW'(1);
    assign sec_idx  = push_idx - AW'(2);
    assign top_val  = mem[top_idx];
    assign sec_val  = mem[sec_idx];
    assign has_two  = (count_reg >= CW'(2));
    assign empty    = (count_reg == '0);
    assign full     = (count_reg == CW'(DEPTH));

    logic signed [N-1:0]   s_op, t_op, sum, diff;
    logic signed [2*N-1:0] s_ext, t_ext, prod;
    logic [N-1:0]          arith_raw, arith_res;
    logic                  arith_ovf, true_neg;

    assign s_op  = sec_val;
    assign t_op  = top_val;
    assign sum   = s_op + t_op;
    assign diff  = s_op - t_op;
    assign s_ext = {{N{s_op[N-1]}}, s_op};
    assign t_ext = {{N{t_op[N-1]}}, t_op};
    assign prod  = s_ext * t_ext;

    always_comb begin
        arith_raw = sum;
        arith_ovf = (s_op[N-1] == t_op[N-1]) && (sum[N-1] != s_op[N-1]);
        true_neg  = s_op[N-1];
        case (opcode)
            OP_SUB: begin
                arith_raw = diff;
                arith_ovf = (s_op[N-1] != t_op[N-1]) && (diff[N-1] != s_op[N-1]);
                true_neg  = s_op[N-1];
            end
            OP_MUL: begin
                arith_raw = prod[N-1:0];
                // Fits in N bits only if the top N+1 product bits are a pure sign extension.
                arith_ovf = !((&prod[2*N-1:N-1]) || (~|prod[2*N-1:N-1]));
                true_neg  = prod[2*N-1];
            end
            default: ;
        endcase
`ifdef STACK_ALU_SAT_EN
        if (arith_ovf)
            arith_res = true_neg ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
        else
            arith_res = arith_raw;
`else
        arith_res = arith_raw;
`endif
    end

    logic          wr0_en, wr1_en;
    logic [AW-1:0] wr0_idx, wr1_idx;
    logic [N-1:0]  wr0_data, wr1_data;

    always_comb begin
        err_next   = 1'b0;
        count_next = count_reg;
        out_next   = out_reg;
        ovf_next   = ovf_reg;
        wr0_en     = 1'b0;
        wr0_idx    = push_idx;
        wr0_data   = input_data;
        wr1_en     = 1'b0;
        wr1_idx    = sec_idx;
        wr1_data   = arith_res;
        case (opcode)
            OP_PUSH: begin
                if (full) err_next = 1'b1;
                else begin
                    wr0_en     = 1'b1;
                    count_next = count_reg + CW'(1);
                end
            end
            OP_POP: begin
                if (empty) err_next = 1'b1;
                else begin
                    out_next   = top_val;
                    count_next = count_reg - CW'(1);
                end
            end
            OP_DUP: begin
                if (empty || full) err_next = 1'b1;
                else begin
                    wr0_en     = 1'b1;
                    wr0_data   = top_val;
                    count_next = count_reg + CW'(1);
                end
            end
            OP_ADD, OP_SUB, OP_MUL: begin
                if (!has_two) err_next = 1'b1;
                else begin
                    wr1_en     = 1'b1;
                    out_next   = arith_res;
                    ovf_next   = arith_ovf;
                    count_next = count_reg - CW'(1);
                end
            end
            OP_SWAP: begin
                if (!has_two) err_next = 1'b1;
                else begin
                    wr0_en   = 1'b1;
                    wr0_idx  = top_idx;
                    wr0_data = sec_val;
                    wr1_en   = 1'b1;
                    wr1_data = top_val;
                end
            end
            OP_CLEAR: begin
                count_next = '0;
                ovf_next   = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
            out_reg   <= '0;
            ovf_reg   <= 1'b0;
            err_reg   <= 1'b0;
        end else begin
            count_reg <= count_next;
            out_reg   <= out_next;
            ovf_reg   <= ovf_next;
            err_reg   <= err_next;
        end
    end

    // Storage is deliberately left out of reset; writes are suppressed while reset is held.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (wr0_en) mem[wr0_idx] <= wr0_data;
            if (wr1_en) mem[wr1_idx] <= wr1_data;
        end
    end

    assign count       = count_reg;
    assign output_data = out_reg;
    assign overflow    = ovf_reg;
    assign error       = err_reg;
endmodule

// File: tb/tb_stack_alu_param.sv
// Randomised and directed bench for stack_alu_param (N=32, DEPTH=8) against a queue-based reference model.
// Build with STACK_ALU_SAT_EN defined to expect saturating arithmetic.
module tb_stack_alu_param;
    localparam int N     = 32;
    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [3:0]    opcode = 4'h0;
    logic [N-1:0]  input_data = '0;
    logic [N-1:0]  output_data;
    logic          overflow, error, empty, full;
    logic [CW-1:0] count;

    stack_alu_param #(.N(N), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .input_data(input_data),
        .output_data(output_data), .overflow(overflow), .error(error),
        .empty(empty), .full(full), .count(count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: the stack is a plain queue, arithmetic is done exactly in 64 bits.
    logic signed [31:0] stk [$];
    logic [31:0]        m_out = '0;
    logic               m_ovf = 1'b0;
    logic               m_err = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        longint s, t, r;
        logic [31:0] res;
        logic signed [31:0] tmp;
        if (!rst_n) begin
            stk.delete();
            m_out = '0;
            m_ovf = 1'b0;
            m_err = 1'b0;
            return;
        end
        m_err = 1'b0;
        case (opcode)
            4'h6: if (stk.size() == DEPTH) m_err = 1'b1; else stk.push_back(input_data);
            4'h7: if (stk.size() == 0) m_err = 1'b1; else m_out = stk.pop_back();
            4'h9: if (stk.size() == 0 || stk.size() == DEPTH) m_err = 1'b1;
                  else stk.push_back(stk[stk.size()-1]);
            4'h4, 4'h5, 4'h8: begin
                if (stk.size() < 2) m_err = 1'b1;
                else begin
                    t = stk.pop_back();
                    s = stk.pop_back();
                    if (opcode == 4'h4)      r = s + t;
                    else if (opcode == 4'h8) r = s - t;
                    else                     r = s * t;
                    m_ovf = (r > 64'sd2147483647) || (r < -64'sd2147483648);
`ifdef STACK_ALU_SAT_EN
                    if (m_ovf) res = (r < 0) ? 32'h8000_0000 : 32'h7FFF_FFFF;
                    else       res = r[31:0];
`else
                    res = r[31:0];
`endif
                    m_out = res;
                    stk.push_back(res);
                end
            end
            4'hA: if (stk.size() < 2) m_err = 1'b1;
                  else begin
                      tmp = stk[stk.size()-1];
                      stk[stk.size()-1] = stk[stk.size()-2];
                      stk[stk.size()-2] = tmp;
                  end
            4'hB: begin
                stk.delete();
                m_ovf = 1'b0;
            end
            default: ;
        endcase
    endtask

    // Compare process: model advances on each rising edge, DUT checked 1 time unit later.
    initial begin
        forever begin
            @(posedge clk);
            model_step();
            #1;
            chk("output_data", output_data, m_out);
            chk("overflow", 32'(overflow), 32'(m_ovf));
            chk("error", 32'(error), 32'(m_err));
            chk("count", 32'(count), 32'(stk.size()));
            chk("empty", 32'(empty), 32'(stk.size() == 0));
            chk("full", 32'(full), 32'(stk.size() == DEPTH));
        end
    end

    task automatic do_op(input logic [3:0] o, input logic [31:0] d);
        @(negedge clk);
        opcode = o;
        input_data = d;
        @(posedge clk);
        #2;
        $display("op %h in %h -> out %h ovf %b err %b count %0d", o, d, output_data, overflow, error, count);
    endtask

    task automatic do_reset();
        @(negedge clk);
        opcode = 4'h0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    logic [31:0] sat_or_wrap;
    int          pick;
    logic [3:0]  rop;
    logic [31:0] rdata;
    logic [3:0]  undef_codes [7];

    initial begin
        undef_codes = '{4'h1, 4'h2, 4'h3, 4'hC, 4'hD, 4'hE, 4'hF};
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Basic ADD then POP
        do_op(4'h6, 32'd14);
        do_op(4'h6, 32'd717);
        do_op(4'h4, 32'd0);
        chk("add_result", output_data, 32'd731);
        chk("add_ovf", 32'(overflow), 32'd0);
        do_op(4'h7, 32'd0);
        chk("pop_result", output_data, 32'd731);
        chk("pop_count", 32'(count), 32'd0);
        chk("pop_empty", 32'(empty), 32'd1);

        // MUL and ADD overflow
        do_op(4'h6, 32'(-45760));
        do_op(4'h6, 32'd245400);
        do_op(4'h5, 32'd0);
`ifdef STACK_ALU_SAT_EN
        sat_or_wrap = 32'h8000_0000;
`else
        sat_or_wrap = 32'd1655397888;
`endif
        chk("mul_result", output_data, sat_or_wrap);
        chk("mul_ovf", 32'(overflow), 32'd1);
        do_op(4'h6, 32'h7FFF_FFFF);
        do_op(4'h6, 32'd1);
        do_op(4'h4, 32'd0);
`ifdef STACK_ALU_SAT_EN
        sat_or_wrap = 32'h7FFF_FFFF;
`else
        sat_or_wrap = 32'h8000_0000;
`endif
        chk("add_ovf_result", output_data, sat_or_wrap);
        chk("add_ovf_flag", 32'(overflow), 32'd1);
        do_op(4'hB, 32'd0);
        chk("clear_ovf", 32'(overflow), 32'd0);

        // Fill to full, overflowing PUSH is dropped
        for (int i = 1; i <= DEPTH; i++) do_op(4'h6, 32'(i));
        chk("full_flag", 32'(full), 32'd1);
        chk("full_count", 32'(count), 32'd8);
        do_op(4'h6, 32'd99);
        chk("push_full_err", 32'(error), 32'd1);
        chk("push_full_count", 32'(count), 32'd8);
        do_op(4'h7, 32'd0);
        chk("pop_after_full", output_data, 32'd8);
        chk("err_cleared", 32'(error), 32'd0);
        do_op(4'hB, 32'd0);

        // Underflow errors from reset
        do_reset();
        do_op(4'h7, 32'd0);
        chk("pop_empty_err", 32'(error), 32'd1);
        chk("pop_empty_out", output_data, 32'd0);
        do_op(4'h6, 32'd1);
        do_op(4'h4, 32'd0);
        chk("add_one_err", 32'(error), 32'd1);
        chk("add_one_out", output_data, 32'd0);
        chk("add_one_count", 32'(count), 32'd1);
        do_op(4'hB, 32'd0);

        // SUB / SWAP / DUP
        do_op(4'h6, 32'd20);
        do_op(4'h6, 32'd507);
        do_op(4'h8, 32'd0);
        chk("sub_result", output_data, 32'(-487));
        do_op(4'h6, 32'd3);
        do_op(4'h6, 32'd10);
        do_op(4'hA, 32'd0);
        do_op(4'h8, 32'd0);
        chk("swap_sub_result", output_data, 32'd7);
        do_op(4'h9, 32'd0);
        do_op(4'h4, 32'd0);
        chk("dup_add_result", output_data, 32'd14);

        // Asynchronous reset in the middle of a cycle
        do_op(4'h6, 32'd5);
        do_op(4'h6, 32'd6);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_rst_count", 32'(count), 32'd0);
        chk("async_rst_empty", 32'(empty), 32'd1);
        chk("async_rst_out", output_data, 32'd0);
        chk("async_rst_ovf", 32'(overflow), 32'd0);
        @(negedge clk);
        opcode = 4'h0;
        @(negedge clk);
        rst_n = 1'b1;
        do_op(4'h6, 32'd9);
        do_op(4'h7, 32'd0);
        chk("post_rst_pop", output_data, 32'd9);

        // Randomised traffic
        for (int k = 0; k < 400; k++) begin
            pick = int'($urandom_range(0, 99));
            if      (pick < 30) rop = 4'h6;
            else if (pick < 45) rop = 4'h7;
            else if (pick < 53) rop = 4'h4;
            else if (pick < 61) rop = 4'h8;
            else if (pick < 69) rop = 4'h5;
            else if (pick < 76) rop = 4'h9;
            else if (pick < 83) rop = 4'hA;
            else if (pick < 86) rop = 4'hB;
            else if (pick < 90) rop = 4'h0;
            else                rop = undef_codes[$urandom_range(0, 6)];
            case ($urandom_range(0, 3))
                0: rdata = $urandom;
                1: rdata = 32'($urandom_range(0, 200)) - 32'd100;
                2: rdata = ($urandom_range(0, 1) == 1) ? 32'h7FFF_FFFF : 32'h8000_0000;
                default: rdata = 32'($urandom_range(0, 70000)) - 32'd35000;
            endcase
            if ($urandom_range(0, 99) == 0) do_reset();
            else do_op(rop, rdata);
        end

        @(negedge clk);
        opcode = 4'h0;
        @(posedge clk);
        #3;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
